// File: rtl/tb_crc_attach.sv
// tb_crc_attach: appends CRC16/CRC24A to a transport block and packs bytes into MAX_ZC-bit message blocks.
module tb_crc_attach #(
    parameter int MAX_ZC = 384
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tb_start,
    input  logic [13:0]       tb_size,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [MAX_ZC-1:0] msg_block,
    output logic              new_msg_block,
    output logic [13:0]       tb_with_crc_size,
    output logic              tb_valid,
    output logic              cfg_err
);
    localparam int BYTES_PER_BLK = MAX_ZC / 8;
    localparam int PW = $clog2(BYTES_PER_BLK + 1);

    typedef enum logic [2:0] {IDLE, LOAD, CRC, FLUSH, GAP} state_t;

    state_t            state, state_nxt;
    logic [10:0]       a_bytes, byte_cnt;
    logic [1:0]        crc_idx;
    logic              crc_long;
    logic [23:0]       crc;
    logic [MAX_ZC-1:0] pack, pack_wr;
    logic [PW-1:0]     pidx;
    logic              size_ok, start_ok, accept, wr_en, last_pay, last_crc, blk_full;
    logic [7:0]        wr_byte;

    function automatic logic [23:0] crc_step(input logic [23:0] c, input logic [7:0] d, input logic long_crc);
        logic [23:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (long_crc) r = {r[22:0], 1'b0} ^ ((r[23] ^ d[i]) ? 24'h864CFB : 24'h0);
            else r = {8'h0, r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 24'h001021 : 24'h0);
        end
        return r;
    endfunction

    assign size_ok  = tb_size[2:0] == 3'd0 && tb_size >= 14'd24 && tb_size <= 14'd8424;
    assign start_ok = state == IDLE && tb_start && size_ok;
    assign in_ready = state == LOAD;
    assign accept   = in_ready && in_valid;
    assign wr_en    = accept || state == CRC;
    assign wr_byte  = state == CRC ? (crc_long ? crc[23:16] : crc[15:8]) : in_data;
    assign last_pay = byte_cnt == a_bytes - 11'd1;
    assign last_crc = crc_idx == (crc_long ? 2'd2 : 2'd1);
    assign blk_full = pidx == PW'(BYTES_PER_BLK - 1);

    always_comb begin
        pack_wr = pack;
        pack_wr[8*pidx +: 8] = wr_byte;
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = start_ok ? LOAD : IDLE;
            LOAD:    state_nxt = accept && last_pay ? CRC : LOAD;
            CRC:     state_nxt = last_crc ? FLUSH : CRC;
            FLUSH:   state_nxt = pidx == '0 ? GAP : FLUSH;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_bytes          <= '0;
            byte_cnt         <= '0;
            crc_idx          <= '0;
            crc_long         <= 1'b0;
            crc              <= '0;
            pack             <= '0;
            pidx             <= '0;
            msg_block        <= '0;
            new_msg_block    <= 1'b0;
            tb_with_crc_size <= '0;
            tb_valid         <= 1'b0;
            cfg_err          <= 1'b0;
        end else begin
            new_msg_block <= 1'b0;
            cfg_err       <= state == IDLE && tb_start && !size_ok;
            if (start_ok) begin
                a_bytes          <= tb_size[13:3];
                crc_long         <= tb_size > 14'd3824;
                tb_with_crc_size <= tb_size + (tb_size > 14'd3824 ? 14'd24 : 14'd16);
                tb_valid         <= 1'b1;
                crc              <= '0;
                pack             <= '0;
                pidx             <= '0;
                byte_cnt         <= '0;
                crc_idx          <= '0;
            end
            if (accept) begin
                crc      <= crc_step(crc, in_data, crc_long);
                byte_cnt <= byte_cnt + 11'd1;
            end
            // CRC bytes leave from the top, so shift the register up after each one
            if (state == CRC) begin
                crc     <= crc << 8;
                crc_idx <= crc_idx + 2'd1;
            end
            if (wr_en) begin
                pack          <= blk_full ? '0 : pack_wr;
                pidx          <= blk_full ? '0 : pidx + PW'(1);
                msg_block     <= blk_full ? pack_wr : msg_block;
                new_msg_block <= blk_full;
            end
            if (state == FLUSH) begin
                pack          <= '0;
                pidx          <= '0;
                msg_block     <= pidx != '0 ? pack : msg_block;
                new_msg_block <= pidx != '0;
                tb_valid      <= pidx != '0;
            end
        end
    end
endmodule

// File: tb/tb_tb_crc_attach.sv
// tb_tb_crc_attach: randomized and table-driven bench for tb_crc_attach against a polynomial-division reference.
module tb_tb_crc_attach;
    localparam int ZC  = 384;
    localparam int BPB = ZC / 8;

    typedef struct {
        int size;
        int pat;
        int gaps;
        int poke;
        int exp_size;
        int exp_pulses;
    } vec_t;

    logic          clk = 1'b0, reset_n = 1'b0, tb_start = 1'b0, in_valid = 1'b0;
    logic [13:0]   tb_size = '0;
    logic [7:0]    in_data = '0;
    logic          in_ready, new_msg_block, tb_valid, cfg_err;
    logic [ZC-1:0] msg_block;
    logic [13:0]   tb_with_crc_size;

    tb_crc_attach #(.MAX_ZC(ZC)) dut (
        .clk(clk), .reset_n(reset_n), .tb_start(tb_start), .tb_size(tb_size),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .msg_block(msg_block), .new_msg_block(new_msg_block),
        .tb_with_crc_size(tb_with_crc_size), .tb_valid(tb_valid), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int            errs = 0, checks = 0, cfg_cnt = 0;
    logic [ZC-1:0] got[$], saved[$];
    logic [7:0]    pay[$], full[$];
    bit            msg[0:8447];
    vec_t          vecs[9];

    always @(negedge clk) begin
        if (new_msg_block) got.push_back(msg_block);
        if (cfg_err) cfg_cnt++;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_blk(input string name, input logic [ZC-1:0] act, input logic [ZC-1:0] exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: remainder of M(x)*x^L divided by G(x) by long division over the bit string
    task automatic build_model(input int a);
        int l;
        logic [24:0] g;
        logic [7:0] v;
        l = a <= 3824 ? 16 : 24;
        g = l == 16 ? 25'h0011021 : 25'h1864CFB;
        for (int i = 0; i < a + l; i++) msg[i] = i < a ? pay[i/8][7-i%8] : 1'b0;
        for (int i = 0; i < a; i++)
            if (msg[i]) for (int j = 0; j <= l; j++) msg[i+j] ^= g[l-j];
        full = pay;
        for (int k = 0; k < l / 8; k++) begin
            for (int b = 0; b < 8; b++) v[7-b] = msg[a+8*k+b];
            full.push_back(v);
        end
    endtask

    function automatic logic [ZC-1:0] exp_blk(input int b);
        logic [ZC-1:0] r;
        r = '0;
        for (int k = 0; k < BPB; k++)
            if (b * BPB + k < full.size()) r[8*k +: 8] = full[b*BPB+k];
        return r;
    endfunction

    task automatic run_tb(input int a, input int pat, input int gaps, input int poke,
                          input int exp_size, input int exp_pulses);
        int idx, c;
        logic acc, prev;
        if (pat != 3) begin
            pay.delete();
            for (int i = 0; i < a / 8; i++)
                pay.push_back(pat == 1 ? 8'h00 : pat == 2 ? 8'(8'h31 + i) : 8'($urandom));
        end
        build_model(a);
        got.delete();
        cfg_cnt  = 0;
        tb_start = 1'b1;
        tb_size  = 14'(a);
        @(posedge clk); #1;
        tb_start = 1'b0;
        tb_size  = 14'($urandom);
        chk("tb_valid_rise", tb_valid, 1);
        chk("tb_with_crc_size", tb_with_crc_size, exp_size);
        idx = 0;
        c   = 0;
        while (idx < a / 8 && c < 20000) begin
            in_valid = !(gaps != 0 && $urandom % 2 == 1);
            in_data  = pay[idx];
            tb_start = poke != 0 && idx == 3;
            if (tb_start) tb_size = 14'd20;
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            c++;
        end
        in_valid = 1'b0;
        tb_start = 1'b0;
        chk("bytes_accepted", idx, a / 8);
        prev = 1'b0;
        for (c = 0; c < 200 && tb_valid; c++) begin
            prev = new_msg_block;
            @(negedge clk);
        end
        chk("tb_valid_drop", tb_valid, 0);
        chk("pulse_then_drop", prev, 1);
        chk("pulse_count", got.size(), exp_pulses);
        for (int b = 0; b < got.size(); b++) chk_blk($sformatf("block%0d", b), got[b], exp_blk(b));
        chk("no_cfg_err", cfg_cnt, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("in_ready_idle", in_ready, 0);
        chk_blk("msg_block_hold", msg_block, exp_blk(exp_pulses - 1));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{72, 2, 0, 0, 88, 1};
        vecs[1] = '{3832, 1, 0, 0, 3856, 11};
        vecs[2] = '{3824, 0, 0, 0, 3840, 10};
        vecs[3] = '{360, 0, 0, 0, 376, 1};
        vecs[4] = '{24, 0, 1, 0, 40, 1};
        vecs[5] = '{368, 0, 0, 0, 384, 1};
        vecs[6] = '{8424, 0, 0, 0, 8448, 22};
        vecs[7] = '{1000, 0, 0, 0, 1016, 3};
        vecs[8] = '{1000, 3, 1, 1, 1016, 3};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_tb_valid", tb_valid, 0);
        chk("rst_new_msg_block", new_msg_block, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_size", tb_with_crc_size, 0);
        chk_blk("rst_msg_block", msg_block, '0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_tb(vecs[i].size, vecs[i].pat, vecs[i].gaps, vecs[i].poke, vecs[i].exp_size, vecs[i].exp_pulses);
            if (i == 0) chk("crc16_123456789", got.size() > 0 ? {got[0][79:72], got[0][87:80]} : 16'h0, 16'h31C3);
            if (i == 7) saved = got;
            if (i == 8) begin
                chk("gap_vs_nogap_count", got.size(), saved.size());
                for (int b = 0; b < got.size() && b < saved.size(); b++)
                    chk_blk($sformatf("gap_vs_nogap%0d", b), got[b], saved[b]);
            end
        end

        foreach (vecs[i]) begin
            int bad;
            if (i > 2) break;
            bad = i == 0 ? 20 : i == 1 ? 12 : 8432;
            tb_start = 1'b1;
            tb_size  = 14'(bad);
            @(posedge clk); #1;
            tb_start = 1'b0;
            chk($sformatf("cfg_err_%0d", bad), cfg_err, 1);
            chk($sformatf("rej_tb_valid_%0d", bad), tb_valid, 0);
            chk($sformatf("rej_in_ready_%0d", bad), in_ready, 0);
            @(posedge clk); #1;
            chk($sformatf("cfg_err_pulse_%0d", bad), cfg_err, 0);
        end

        for (int r = 0; r < 4; r++) begin
            int a, l;
            a = 8 * $urandom_range(1053, 3);
            l = a <= 3824 ? 16 : 24;
            run_tb(a, 0, $urandom % 2, 0, a + l, (a + l + ZC - 1) / ZC);
        end

        tb_start = 1'b1;
        tb_size  = 14'd576;
        @(posedge clk); #1;
        tb_start = 1'b0;
        in_valid = 1'b1;
        repeat (30) begin
            in_data = 8'($urandom);
            @(posedge clk); #1;
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_tb_valid", tb_valid, 0);
        chk("mid_rst_new_msg_block", new_msg_block, 0);
        chk("mid_rst_size", tb_with_crc_size, 0);
        chk_blk("mid_rst_msg_block", msg_block, '0);
        in_valid = 1'b0;
        got.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("no_pulse_after_rst", got.size(), 0);
        run_tb(72, 2, 0, 0, 88, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
